// File: rtl/c3po_arb_pkg.sv
// Shared types and field widths for the c3po input-side arbiters.
package c3po_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

  localparam int C3PO_VBC_W = 8;
  localparam int C3PO_ID_W  = 4;

endpackage

// File: rtl/c3po_rr_pick.sv
// Combinational round-robin picker: first request strictly after last_grant,
// wrapping around, returned both one-hot and as an index.
module c3po_rr_pick #(
  parameter int NUM_REQ_P = 4
) (
  input  logic [NUM_REQ_P-1:0]         req,
  input  logic [$clog2(NUM_REQ_P)-1:0] last_grant,
  output logic                         gnt_vld,
  output logic [NUM_REQ_P-1:0]         gnt_oh,
  output logic [$clog2(NUM_REQ_P)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(NUM_REQ_P);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Offsets 1..N from last_grant; the last offset revisits last_grant itself.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_oh   = '0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= NUM_REQ_P; off++) begin
      cand = int'(last_grant) + off;
      if (cand >= NUM_REQ_P) cand = cand - NUM_REQ_P;
      cand_idx = IDX_W'(cand);
      if (!gnt_vld && req[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/c3po_in_arb.sv
// Packet-level round-robin arbiter in front of the c3po input port.
// Optional build macro C3PO_ARB_ID_OVERRIDE_EN replaces sig_id with the owner index.
module c3po_in_arb
  import c3po_arb_pkg::*;
#(
  parameter int NUM_SRC_P = 4,
  parameter int DATA_W_P  = 1280
) (
  input  logic                            sig_clock,
  input  logic                            sig_reset_L,
  input  logic [NUM_SRC_P-1:0]            src_val,
  input  logic [NUM_SRC_P-1:0]            src_sop,
  input  logic [NUM_SRC_P-1:0]            src_eop,
  input  logic [NUM_SRC_P*C3PO_VBC_W-1:0] src_vbc,
  input  logic [NUM_SRC_P*C3PO_ID_W-1:0]  src_id,
  input  logic [NUM_SRC_P*DATA_W_P-1:0]   src_data,
  input  logic [NUM_SRC_P-1:0]            src_en,
  output logic [NUM_SRC_P-1:0]            src_rdy,
  input  logic                            sig_ready,
  output logic                            sig_sop,
  output logic                            sig_eop,
  output logic                            sig_val,
  output logic [C3PO_VBC_W-1:0]           sig_vbc,
  output logic [C3PO_ID_W-1:0]            sig_id,
  output logic [DATA_W_P-1:0]             sig_data,
  output logic [$clog2(NUM_SRC_P)-1:0]    grant_owner,
  output logic                            err_sop
);

  localparam int IDX_W = $clog2(NUM_SRC_P);

  arb_state_t             state;
  logic [NUM_SRC_P-1:0]   owner_oh;
  logic [IDX_W-1:0]       last_grant;
  logic                   first_beat;

  logic [NUM_SRC_P-1:0]   pick_req;
  logic [NUM_SRC_P-1:0]   pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_vld;

  logic                   own_val;
  logic                   own_sop;
  logic                   own_eop;
  logic [C3PO_VBC_W-1:0]  own_vbc;
  logic [C3PO_ID_W-1:0]   own_id;
  logic [DATA_W_P-1:0]    own_data;
  logic [C3PO_ID_W-1:0]   beat_id;
  logic                   xfer;

  assign pick_req = src_val & src_sop & src_en;

  c3po_rr_pick #(
    .NUM_REQ_P (NUM_SRC_P)
  ) u_pick (
    .req        (pick_req),
    .last_grant (last_grant),
    .gnt_vld    (pick_vld),
    .gnt_oh     (pick_oh),
    .gnt_idx    (pick_idx)
  );

  // AND-OR select of the owner's beat using the registered one-hot grant.
  always_comb begin
    own_val  = 1'b0;
    own_sop  = 1'b0;
    own_eop  = 1'b0;
    own_vbc  = '0;
    own_id   = '0;
    own_data = '0;
    for (int i = 0; i < NUM_SRC_P; i++) begin
      if (owner_oh[i]) begin
        own_val  = src_val[i];
        own_sop  = src_sop[i];
        own_eop  = src_eop[i];
        own_vbc  = src_vbc[i*C3PO_VBC_W +: C3PO_VBC_W];
        own_id   = src_id[i*C3PO_ID_W +: C3PO_ID_W];
        own_data = src_data[i*DATA_W_P +: DATA_W_P];
      end
    end
  end

`ifdef C3PO_ARB_ID_OVERRIDE_EN
  assign beat_id = C3PO_ID_W'(grant_owner);
`else
  assign beat_id = own_id;
`endif

  assign src_rdy = (state == ARB_LOCK) ? (owner_oh & {NUM_SRC_P{sig_ready}}) : '0;
  assign xfer    = (state == ARB_LOCK) & own_val & sig_ready;

  // sig_ready already gated the transfer, so the output stage never has to stall.
  always_ff @(posedge sig_clock or negedge sig_reset_L) begin
    if (!sig_reset_L) begin
      state       <= ARB_IDLE;
      owner_oh    <= '0;
      grant_owner <= '0;
      last_grant  <= IDX_W'(NUM_SRC_P - 1);
      first_beat  <= 1'b0;
      sig_val     <= 1'b0;
      sig_sop     <= 1'b0;
      sig_eop     <= 1'b0;
      sig_vbc     <= '0;
      sig_id      <= '0;
      sig_data    <= '0;
      err_sop     <= 1'b0;
    end else begin
      sig_val <= xfer;
      err_sop <= xfer & own_sop & ~first_beat;
      if (xfer) begin
        sig_sop  <= own_sop;
        sig_eop  <= own_eop;
        sig_vbc  <= own_vbc;
        sig_id   <= beat_id;
        sig_data <= own_data;
      end
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            owner_oh    <= pick_oh;
            grant_owner <= pick_idx;
            first_beat  <= 1'b1;
            state       <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          if (xfer) begin
            first_beat <= 1'b0;
            if (own_eop) begin
              last_grant <= grant_owner;
              state      <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c3po_in_arb.sv
// Self-checking bench for c3po_in_arb: directed table, packet sequences and random traffic
// against a packet-level reference model (honours C3PO_ARB_ID_OVERRIDE_EN).
`timescale 1ns/1ps
module tb_c3po_in_arb;

  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst_l;
  logic [N-1:0]    src_val, src_sop, src_eop, src_en, src_rdy;
  logic [N*8-1:0]  src_vbc;
  logic [N*4-1:0]  src_id;
  logic [N*DW-1:0] src_data;
  logic            sig_ready, sig_sop, sig_eop, sig_val, err_sop;
  logic [7:0]      sig_vbc;
  logic [3:0]      sig_id;
  logic [DW-1:0]   sig_data;
  logic [1:0]      grant_owner;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  c3po_in_arb #(.NUM_SRC_P(N), .DATA_W_P(DW)) dut (
    .sig_clock   (clk),
    .sig_reset_L (rst_l),
    .src_val     (src_val),
    .src_sop     (src_sop),
    .src_eop     (src_eop),
    .src_vbc     (src_vbc),
    .src_id      (src_id),
    .src_data    (src_data),
    .src_en      (src_en),
    .src_rdy     (src_rdy),
    .sig_ready   (sig_ready),
    .sig_sop     (sig_sop),
    .sig_eop     (sig_eop),
    .sig_val     (sig_val),
    .sig_vbc     (sig_vbc),
    .sig_id      (sig_id),
    .sig_data    (sig_data),
    .grant_owner (grant_owner),
    .err_sop     (err_sop)
  );

  // Reference model: which source owns the bus, who went last, and the beat last forwarded.
  bit            m_lock, m_first;
  int            m_owner, m_last;
  logic          e_val, e_sop, e_eop, e_err;
  logic [7:0]    e_vbc;
  logic [3:0]    e_id;
  logic [DW-1:0] e_data;

  // Source drivers and observation state.
  bit            drvOn, drvRepeat, randOn;
  bit            active[N];
  int            pktLen[N], beatIdx[N], sopAt[N];
  logic [DW-1:0] outData[$];
  logic [3:0]    outId[$];
  int            errPulses;
  logic [DW-1:0] errData;
  logic [N-1:0]  snapRdy;
  logic          snapVal, snapSop, snapEop;
  logic [7:0]    snapVbc;
  logic [1:0]    snapOwner;

  typedef struct {
    logic [N-1:0] val, sop, eop;
    logic [7:0]   vbc;
    logic         rdy;
    logic [N-1:0] expRdy;
    logic         expVal, expSop, expEop;
    logic [7:0]   expVbc;
    logic [1:0]   expOwner;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    m_lock = 0; m_first = 0; m_owner = 0; m_last = N - 1;
    e_val = 0; e_sop = 0; e_eop = 0; e_err = 0; e_vbc = '0; e_id = '0; e_data = '0;
  endtask

  // Apply the arbitration rules to the inputs present during the current cycle.
  task automatic modelAdvance();
    if (!m_lock) begin
      e_val = 0;
      e_err = 0;
      for (int k = 1; k <= N; k++) begin
        int s;
        s = (m_last + k) % N;
        if (!m_lock && src_val[s] && src_sop[s] && src_en[s]) begin
          m_lock = 1; m_owner = s; m_first = 1;
        end
      end
    end else begin
      bit x;
      x = src_val[m_owner] && sig_ready;
      e_val = x;
      e_err = x && src_sop[m_owner] && !m_first;
      if (x) begin
        e_sop  = src_sop[m_owner];
        e_eop  = src_eop[m_owner];
        e_vbc  = src_vbc[m_owner*8 +: 8];
`ifdef C3PO_ARB_ID_OVERRIDE_EN
        e_id   = 4'(m_owner);
`else
        e_id   = src_id[m_owner*4 +: 4];
`endif
        e_data = src_data[m_owner*DW +: DW];
        m_first = 0;
        if (src_eop[m_owner]) begin
          m_last = m_owner;
          m_lock = 0;
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic [N-1:0] expRdy;
    expRdy = m_lock ? (N'(sig_ready) << m_owner) : '0;
    chk("src_rdy", src_rdy, expRdy);
    chk("sig_val", sig_val, e_val);
    chk("sig_sop", sig_sop, e_sop);
    chk("sig_eop", sig_eop, e_eop);
    chk("sig_vbc", sig_vbc, e_vbc);
    chk("sig_id", sig_id, e_id);
    chk("sig_data", sig_data, e_data);
    chk("grant_owner", grant_owner, 64'(m_owner));
    chk("err_sop", err_sop, e_err);
  endtask

  task automatic applyStimulus(input vec_t v);
    src_val = v.val; src_sop = v.sop; src_eop = v.eop; src_en = '1;
    sig_ready = v.rdy;
    src_vbc = '0; src_id = '0; src_data = '0;
    src_vbc[2*8 +: 8]   = v.vbc;
    src_id[2*4 +: 4]    = 4'd2;
    src_data[2*DW +: DW] = 64'(v.vbc);
  endtask

  task automatic driveSources();
    for (int s = 0; s < N; s++) begin
      if (active[s]) begin
        src_val[s] = 1'b1;
        src_sop[s] = (beatIdx[s] == 0) || (beatIdx[s] == sopAt[s]);
        src_eop[s] = (beatIdx[s] == pktLen[s] - 1);
        src_vbc[s*8 +: 8]    = src_eop[s] ? 8'd17 : 8'd160;
        src_id[s*4 +: 4]     = 4'(s);
        src_data[s*DW +: DW] = 64'(s*16 + beatIdx[s]);
      end else begin
        src_val[s] = 1'b0; src_sop[s] = 1'b0; src_eop[s] = 1'b0;
      end
    end
  endtask

  task automatic randomizeInputs();
    src_val   = N'($urandom);
    src_sop   = N'($urandom);
    src_eop   = N'($urandom & $urandom);
    src_en    = N'($urandom | $urandom);
    sig_ready = ($urandom_range(0, 3) != 0);
    for (int s = 0; s < N; s++) begin
      src_vbc[s*8 +: 8]    = 8'($urandom);
      src_id[s*4 +: 4]     = 4'($urandom);
      src_data[s*DW +: DW] = {$urandom, $urandom};
    end
  endtask

  task automatic clearAll();
    drvOn = 0; drvRepeat = 0; randOn = 0;
    src_val = '0; src_sop = '0; src_eop = '0; src_en = '0; sig_ready = 1'b0;
    src_vbc = '0; src_id = '0; src_data = '0;
    for (int s = 0; s < N; s++) begin
      active[s] = 0; pktLen[s] = 1; beatIdx[s] = 0; sopAt[s] = -1;
    end
    outData.delete(); outId.delete();
    errPulses = 0; errData = '0;
  endtask

  // Asserts reset wherever the caller is in the cycle, checks the asynchronous clear.
  task automatic doReset();
    rst_l = 1'b0;
    modelReset();
    clearAll();
    #1;
    checkOutput();
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    checkOutput();
    snapRdy = src_rdy; snapVal = sig_val; snapSop = sig_sop; snapEop = sig_eop;
    snapVbc = sig_vbc; snapOwner = grant_owner;
    if (sig_val) begin
      outData.push_back(sig_data);
      outId.push_back(sig_id);
    end
    if (err_sop) begin
      errPulses++;
      errData = sig_data;
    end
    acc = src_rdy & src_val;
    modelAdvance();
    @(posedge clk);
    #1;
    if (drvOn) begin
      for (int s = 0; s < N; s++) begin
        if (active[s] && acc[s]) begin
          beatIdx[s]++;
          if (beatIdx[s] == pktLen[s]) begin
            beatIdx[s] = 0;
            if (!drvRepeat) active[s] = 0;
          end
        end
      end
      driveSources();
    end else if (randOn) begin
      randomizeInputs();
    end
  endtask

  initial begin
    tbl[0] = '{4'b0100, 4'b0100, 4'b0000, 8'd160, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0,   2'd0};
    tbl[1] = '{4'b0100, 4'b0100, 4'b0000, 8'd160, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 8'd0,   2'd2};
    tbl[2] = '{4'b0100, 4'b0000, 4'b0000, 8'd160, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 8'd160, 2'd2};
    tbl[3] = '{4'b0100, 4'b0000, 4'b0100, 8'd17,  1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 8'd160, 2'd2};
    tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 8'd0,   1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 8'd17,  2'd2};
    tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 8'd0,   1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd17,  2'd2};

    rst_l = 1'b0;
    #2;
    doReset();

    // Source 2 alone, 3-beat packet.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i]);
      tick();
      chk($sformatf("tbl%0d_rdy", i), snapRdy, tbl[i].expRdy);
      chk($sformatf("tbl%0d_val", i), snapVal, tbl[i].expVal);
      chk($sformatf("tbl%0d_sop", i), snapSop, tbl[i].expSop);
      chk($sformatf("tbl%0d_eop", i), snapEop, tbl[i].expEop);
      chk($sformatf("tbl%0d_vbc", i), snapVbc, tbl[i].expVbc);
      chk($sformatf("tbl%0d_owner", i), snapOwner, tbl[i].expOwner);
    end

    // All sources streaming single-beat packets.
    doReset();
    begin
      int b2b;
      logic prevVal;
      logic [3:0] expOrder[5];
      expOrder = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
      b2b = 0; prevVal = 1'b0;
      drvOn = 1; drvRepeat = 1; src_en = '1; sig_ready = 1'b1;
      for (int s = 0; s < N; s++) begin active[s] = 1; pktLen[s] = 1; end
      driveSources();
      for (int t = 0; t < 12; t++) begin
        tick();
        if (prevVal && snapVal) b2b++;
        prevVal = snapVal;
      end
      chk("rr_bubble", 64'(b2b), 64'd0);
      chk("rr_count_ge5", 64'(outId.size() >= 5), 64'd1);
      for (int i = 0; i < 5 && i < outId.size(); i++)
        chk($sformatf("rr_order%0d", i), outId[i], expOrder[i]);
    end

    // Backpressure in the middle of a source 1 packet.
    doReset();
    drvOn = 1; src_en = '1; active[1] = 1; pktLen[1] = 4;
    driveSources();
    for (int t = 0; t < 10; t++) begin
      sig_ready = !(t == 3 || t == 4);
      tick();
      if (t == 3 || t == 4) chk($sformatf("bp_rdy_low%0d", t), snapRdy[1], 1'b0);
      if (t == 4 || t == 5) chk($sformatf("bp_no_val%0d", t), snapVal, 1'b0);
    end
    chk("bp_beats", 64'(outData.size()), 64'd4);
    for (int i = 0; i < 4 && i < outData.size(); i++)
      chk($sformatf("bp_data%0d", i), outData[i], 64'(16 + i));

    // Disabled source 0 loses; source 3 keeps its grant after its enable drops.
    doReset();
    drvOn = 1; sig_ready = 1'b1; src_en = 4'b1000;
    active[0] = 1; pktLen[0] = 1;
    active[3] = 1; pktLen[3] = 4;
    driveSources();
    for (int t = 0; t < 10; t++) begin
      if (t == 2) src_en = '0;
      tick();
      if (t == 1) chk("en_owner", snapOwner, 2'd3);
    end
    chk("en_beats", 64'(outId.size()), 64'd4);
    for (int i = 0; i < outId.size(); i++)
      chk($sformatf("en_id%0d", i), outId[i], 4'd3);

    // Second sop inside a packet.
    doReset();
    drvOn = 1; sig_ready = 1'b1; src_en = '1;
    active[2] = 1; pktLen[2] = 3; sopAt[2] = 1;
    driveSources();
    for (int t = 0; t < 8; t++) tick();
    chk("err_pulses", 64'(errPulses), 64'd1);
    chk("err_data", errData, 64'd33);
    chk("err_beats", 64'(outData.size()), 64'd3);

    // Reset in the middle of a source 2 packet, then 0 and 2 compete.
    doReset();
    drvOn = 1; sig_ready = 1'b1; src_en = '1;
    active[2] = 1; pktLen[2] = 4;
    driveSources();
    for (int t = 0; t < 3; t++) tick();
    chk("pre_rst_val", snapVal, 1'b1);
    #2;
    doReset();
    drvOn = 1; sig_ready = 1'b1; src_en = '1;
    active[0] = 1; active[2] = 1;
    driveSources();
    tick();
    tick();
    chk("rst_winner", snapOwner, 2'd0);

    // Random traffic against the model.
    doReset();
    randOn = 1;
    randomizeInputs();
    for (int t = 0; t < 600; t++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/c3po_in_arb.md
Name: c3po_in_arb

Overview:
- Packet-level round-robin arbiter that shares the single c3po input bus among NUM_SRC_P upstream sources.
- A grant is held from the sop beat through the eop beat, so packets never interleave.
- Honours c3po backpressure through sig_ready, and sits directly in front of the c3po input port.
- The granted beat is driven onto sig_sop/sig_eop/sig_val/sig_vbc/sig_id/sig_data through one register stage.

Parameters:
- NUM_SRC_P, 4, number of requesting sources (2..8).
- DATA_W_P, 1280, beat data width in bits (160 bytes).

Ports:
- sig_clock  in  1  clock.
- sig_reset_L  in  1  asynchronous active-low reset.
- src_val  in  NUM_SRC_P  per-source beat valid.
- src_sop  in  NUM_SRC_P  per-source start of packet.
- src_eop  in  NUM_SRC_P  per-source end of packet.
- src_vbc  in  NUM_SRC_P*8  per-source valid byte count.
- src_id  in  NUM_SRC_P*4  per-source packet id.
- src_data  in  NUM_SRC_P*DATA_W_P  per-source beat data.
- src_en  in  NUM_SRC_P  per-source arbitration enable.
- src_rdy  out  NUM_SRC_P  per-source beat accepted this cycle.
- sig_ready  in  1  c3po can accept the beat presented next cycle.
- sig_sop, sig_eop, sig_val  out  1 each  to c3po.
- sig_vbc  out  8  to c3po.
- sig_id  out  4  to c3po.
- sig_data  out  DATA_W_P  to c3po.
- grant_owner  out  $clog2(NUM_SRC_P)  current owner index (debug).
- err_sop  out  1  one-cycle pulse on protocol error.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - last_grant = NUM_SRC_P-1, so source 0 has first priority.
- FSM states: IDLE, LOCK.
- IDLE:
  - Candidates are sources with src_val & src_sop & src_en.
  - Pick the first candidate searching last_grant+1 upward with wrap-around.
  - Register owner <- winner; go to LOCK next cycle.
  - No src_rdy asserts in IDLE, so there is one bubble cycle per packet.
- LOCK:
  - src_rdy[owner] = sig_ready; all other src_rdy = 0.
  - Transfer = src_val[owner] & src_rdy[owner].
  - On transfer, the owner's sop/eop/vbc/id/data are registered to the outputs and sig_val=1 the next cycle; otherwise sig_val=0 next cycle and the other outputs hold.
  - Latency is exactly 1 cycle from transfer to output.
  - Ready contract: a beat presented with sig_val=1 was permitted by sig_ready=1 in the previous cycle. The arbiter never needs to hold a beat.
- Packet end:
  - A transfer with src_eop[owner]=1 sets last_grant <- owner; go to IDLE.
  - A sop&eop single-beat packet is LOCK for one transfer, then IDLE.
- src_en:
  - src_en deasserting mid-packet does not revoke the grant; the packet completes.
  - src_en is only sampled in IDLE.
- Protocol error:
  - A transfer in LOCK with src_sop[owner]=1 on a non-first beat is forwarded unchanged, and err_sop pulses 1 cycle (aligned with the output beat).
- Idle owner: src_val[owner]=0 in LOCK just waits; there is no timeout.
- Reset mid-packet: everything clears immediately, and any partial packet downstream is abandoned.
- Non-candidate beats (val without sop from a non-owner) are not accepted; src_rdy stays 0.

Optional Feature:
- C3PO_ARB_ID_OVERRIDE_EN.
  - Defined: sig_id is driven with the owner index (zero-extended to 4 bits), ignoring src_id.
  - Undefined: sig_id carries src_id[owner] unchanged.

Decomposition:
- Package c3po_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;
  - constants C3PO_VBC_W=8, C3PO_ID_W=4.
- Sub-module c3po_rr_pick: a combinational round-robin picker (request vector plus last_grant in, one-hot and index out), reusable by other arbiters.

Test Plan:
- Src 2 only, 3-beat packet (vbc 160,160,17), sig_ready=1: sig_val on cycles 2..4 after sop is presented, with sop on the 1st beat and eop+vbc=17 on the 3rd; src_rdy[2] high for 3 cycles.
- All 4 sources requesting single-beat packets continuously: grant order 0,1,2,3,0; one idle cycle between beats.
- Src 1 mid-packet, sig_ready low for 2 cycles: src_rdy[1]=0 for those cycles; no sig_val in the following cycles; data order intact; no duplicate beats.
- src_en[0]=0 with sources 0 and 3 requesting: source 3 granted. Clearing src_en[3] mid-packet still completes its 4-beat packet.
- Owner sends a 2nd sop before eop: beat forwarded and err_sop=1 for exactly 1 cycle with it.
- Assert sig_reset_L=0 mid-packet (owner 2): all outputs 0 asynchronously. After release, with sources 2 and 0 requesting, source 0 wins.
